// File: rtl/lfsr_random_gen_if.sv
// Handshake and control bundle for lfsr_random_gen: seed/enable/range inputs,
// the valid/ready sample stream and the period monitor outputs.
interface lfsr_random_gen_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 6
);
  logic [WIDTH-1:0] seed_in;
  logic             seed_load;
  logic             gen_en;
  logic [OUT_W-1:0] range_max;
  logic [OUT_W-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             period_wrap;
  logic [WIDTH-1:0] period_len;

  // Generator side
  modport master (
    input  seed_in,
    input  seed_load,
    input  gen_en,
    input  range_max,
    input  rnd_ready,
    output rnd_data,
    output rnd_valid,
    output period_wrap,
    output period_len
  );

  // Consumer / controller side
  modport slave (
    output seed_in,
    output seed_load,
    output gen_en,
    output range_max,
    output rnd_ready,
    input  rnd_data,
    input  rnd_valid,
    input  period_wrap,
    input  period_len
  );
endinterface

// File: rtl/lfsr_random_gen.sv
// Galois-LFSR random source with seed load, zero-lock guard, range rejection and
// valid/ready output. Optional period monitor enabled by macro LFSR_PERIOD_MON_EN.
module lfsr_random_gen #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               OUT_W = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  lfsr_random_gen_if.master   bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] rnd_data_q, rnd_data_d;
  logic             rnd_valid_q, rnd_valid_d;

  logic [WIDTH-1:0] seed_san;
  logic [WIDTH-1:0] shifted_fb;
  logic [WIDTH-1:0] lfsr_next;
  logic [OUT_W-1:0] cand;
  logic             step;

  assign seed_san = (bus.seed_in == '0) ? ONE : bus.seed_in;

  // Galois step: shift right, fold the tap mask in when the bit leaving is 1
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_fb
    assign shifted_fb[gi] = state_q[gi+1] ^ (state_q[0] & TAPS[gi]);
  end
  assign shifted_fb[WIDTH-1] = state_q[0] & TAPS[WIDTH-1];

  // A bad tap mask could reach the all-zero lock-up state; escape to 1
  assign lfsr_next = (shifted_fb == '0) ? ONE : shifted_fb;

  assign cand = state_q[OUT_W-1:0];
  assign step = bus.gen_en & ~bus.seed_load & (~rnd_valid_q | bus.rnd_ready);

  always_comb begin
    state_d     = state_q;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = rnd_valid_q;
    if (bus.seed_load) begin
      state_d     = seed_san;
      rnd_valid_d = 1'b0;
    end else if (step) begin
      state_d = lfsr_next;
      if (cand <= bus.range_max) begin
        rnd_data_d  = cand;
        rnd_valid_d = 1'b1;
      end else begin
        rnd_valid_d = 1'b0;
      end
    end else if (rnd_valid_q && bus.rnd_ready) begin
      rnd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= seed_san;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign bus.rnd_data  = rnd_data_q;
  assign bus.rnd_valid = rnd_valid_q;

`ifdef LFSR_PERIOD_MON_EN
  logic [WIDTH-1:0] seed_ref_q, seed_ref_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] period_len_q, period_len_d;
  logic             period_wrap_q, period_wrap_d;

  // Wrap is judged on the post-step state against the latched sanitised seed
  always_comb begin
    seed_ref_d    = seed_ref_q;
    step_cnt_d    = step_cnt_q;
    period_len_d  = period_len_q;
    period_wrap_d = 1'b0;
    if (bus.seed_load) begin
      seed_ref_d = seed_san;
      step_cnt_d = '0;
    end else if (step) begin
      if (lfsr_next == seed_ref_q) begin
        period_wrap_d = 1'b1;
        period_len_d  = step_cnt_q + ONE;
        step_cnt_d    = '0;
      end else begin
        step_cnt_d = step_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seed_ref_q    <= seed_san;
      step_cnt_q    <= '0;
      period_len_q  <= '0;
      period_wrap_q <= 1'b0;
    end else begin
      seed_ref_q    <= seed_ref_d;
      step_cnt_q    <= step_cnt_d;
      period_len_q  <= period_len_d;
      period_wrap_q <= period_wrap_d;
    end
  end

  assign bus.period_wrap = period_wrap_q;
  assign bus.period_len  = period_len_q;
`else
  assign bus.period_wrap = 1'b0;
  assign bus.period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Directed bench for lfsr_random_gen: reset, seed sanitising, rejection,
// backpressure, reseed, gen_en hold and the period monitor.
module tb_lfsr_random_gen;
  localparam int WIDTH = 16;
  localparam int OUT_W = 6;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lfsr_random_gen_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

  lfsr_random_gen #(
    .WIDTH (WIDTH),
    .TAPS  (16'hB400),
    .OUT_W (OUT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] seed, input logic [OUT_W-1:0] rmax,
                          input logic rdy);
    reset_n       = 1'b0;
    bus.seed_in   = seed;
    bus.range_max = rmax;
    bus.rnd_ready = rdy;
    bus.gen_en    = 1'b1;
    bus.seed_load = 1'b0;
    tick;
    tick;
    check_val("rst_valid", 32'(bus.rnd_valid), 32'd0);
    check_val("rst_data", 32'(bus.rnd_data), 32'd0);
    check_val("rst_wrap", 32'(bus.period_wrap), 32'd0);
    check_val("rst_len", 32'(bus.period_len), 32'd0);
    reset_n = 1'b1;
  endtask

  logic [15:0] exp_state [4];
  logic [5:0]  exp_data  [4];
  logic [15:0] ace_state [4];
  logic [5:0]  ace_data  [4];
  int          wraps;
  int          wrap_at;

  initial begin
    exp_state = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
    exp_data  = '{6'h01, 6'h00, 6'h00, 6'h00};
    ace_state = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
    ace_data  = '{6'h21, 6'h30, 6'h38, 6'h1C};

    reset_n       = 1'b0;
    bus.seed_in   = 16'h0001;
    bus.seed_load = 1'b0;
    bus.gen_en    = 1'b1;
    bus.range_max = 6'h3F;
    bus.rnd_ready = 1'b1;

    // Basic stream from seed 0001
    do_reset(16'h0001, 6'h3F, 1'b1);
    check_val("rst_state", 32'(dut.state_q), 32'h0001);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_val($sformatf("s1_state%0d", i), 32'(dut.state_q), 32'(exp_state[i]));
      check_val($sformatf("s1_data%0d", i), 32'(bus.rnd_data), 32'(exp_data[i]));
      check_val($sformatf("s1_valid%0d", i), 32'(bus.rnd_valid), 32'd1);
    end

    // Zero seed behaves as seed 0001 (reset applied mid-stream)
    do_reset(16'h0000, 6'h3F, 1'b1);
    check_val("z_state", 32'(dut.state_q), 32'h0001);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_val($sformatf("z_state%0d", i), 32'(dut.state_q), 32'(exp_state[i]));
      check_val($sformatf("z_data%0d", i), 32'(bus.rnd_data), 32'(exp_data[i]));
    end

    // range_max = 0: candidate 01 rejected, 00 accepted
    do_reset(16'h0001, 6'h00, 1'b1);
    tick;
    check_val("rj_valid0", 32'(bus.rnd_valid), 32'd0);
    check_val("rj_state0", 32'(dut.state_q), 32'hB400);
    tick;
    check_val("rj_valid1", 32'(bus.rnd_valid), 32'd1);
    check_val("rj_data1", 32'(bus.rnd_data), 32'h00);

    // Backpressure: sample and state frozen while not ready
    do_reset(16'h0001, 6'h3F, 1'b0);
    tick;
    check_val("bp_first", 32'(bus.rnd_data), 32'h01);
    for (int i = 0; i < 5; i++) begin
      tick;
      check_val($sformatf("bp_data%0d", i), 32'(bus.rnd_data), 32'h01);
      check_val($sformatf("bp_valid%0d", i), 32'(bus.rnd_valid), 32'd1);
      check_val($sformatf("bp_state%0d", i), 32'(dut.state_q), 32'hB400);
    end
    bus.rnd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick;
      check_val($sformatf("bp_rel_state%0d", i), 32'(dut.state_q), 32'(exp_state[i]));
      check_val($sformatf("bp_rel_data%0d", i), 32'(bus.rnd_data), 32'(exp_data[i]));
    end

    // Reseed with ACE1 while a sample is being consumed
    check_val("ld_pre_valid", 32'(bus.rnd_valid), 32'd1);
    bus.seed_in   = 16'hACE1;
    bus.seed_load = 1'b1;
    tick;
    bus.seed_load = 1'b0;
    check_val("ld_valid", 32'(bus.rnd_valid), 32'd0);
    check_val("ld_state", 32'(dut.state_q), 32'hACE1);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_val($sformatf("ace_state%0d", i), 32'(dut.state_q), 32'(ace_state[i]));
      check_val($sformatf("ace_data%0d", i), 32'(bus.rnd_data), 32'(ace_data[i]));
    end

    // gen_en low: pending sample consumed, then state held
    bus.gen_en = 1'b0;
    tick;
    check_val("hold_valid", 32'(bus.rnd_valid), 32'd0);
    tick;
    check_val("hold_state", 32'(dut.state_q), 32'h1C4E);
    check_val("hold_data", 32'(bus.rnd_data), 32'h1C);

    // Full period from seed 0001
    do_reset(16'h0001, 6'h3F, 1'b1);
    wraps   = 0;
    wrap_at = 0;
    for (int i = 0; i < 65535; i++) begin
      tick;
      if (bus.period_wrap) begin
        wraps++;
        wrap_at = i + 1;
      end
    end
    check_val("per_state", 32'(dut.state_q), 32'h0001);
`ifdef LFSR_PERIOD_MON_EN
    check_val("per_wraps", 32'(wraps), 32'd1);
    check_val("per_at", 32'(wrap_at), 32'd65535);
    check_val("per_len", 32'(bus.period_len), 32'h0000FFFF);
    tick;
    check_val("per_pulse_end", 32'(bus.period_wrap), 32'd0);
    check_val("per_len_hold", 32'(bus.period_len), 32'h0000FFFF);
`else
    check_val("per_wraps", 32'(wraps), 32'd0);
    check_val("per_len", 32'(bus.period_len), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
